wash_sequencer: RTL and testbench
=================================

# wash_sequencer

Program sequencer for the washing-machine controller. Runs a selected wash program through FILL, WASH, RINSE and SPIN phases, with a 1 s time base and a per-phase seconds countdown. Drives the four digit codes fed to the `scan4` display scanner, the phase status lights, and the enable for the billing block. It sits between the user inputs (power, start, pause, mode) and the display and billing datapath.

## Interface
- `CLK_HZ`, default 100_000_000: clock cycles per second tick; simulation uses small values.
- `clk` input 1: system clock.
- `rst` input 1: asynchronous, active-high reset.
- `on` input 1: machine power; low forces IDLE.
- `start` input 1: level or pulse; acted on only in IDLE or DONE.
- `pause` input 1: while high, freezes the prescaler and the countdown.
- `mode` input 2: program select, sampled only on accepted start.
- `busy` output 1: high in FILL/WASH/RINSE/SPIN.
- `done` output 1: one-cycle pulse on entry to DONE.
- `bill_on` output 1: equals `busy & ~pause`; drives billing `on`.
- `phase` output 3: current state code.
- `n3`, `n2`, `n1`, `n0` output 4 each: digit codes to `scan4`; 0–9 = digit, 4'd11 = blank.
- `st_light` output 8: phase lights.

## Operation
- States, with `phase` codes: IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4, DONE=5.
- Accepted start: `on & start` in IDLE or DONE. Latch `mode` and go to the first phase with nonzero duration. Load the BCD countdown `{n1,n0}` with that duration and clear the prescaler.
- Program durations, in seconds, for FILL/WASH/RINSE/SPIN:
  - mode0: 10/30/20/15.
  - mode1: 5/15/10/10.
  - mode2: 10/45/20/15.
  - mode3: 0/0/0/15 (spin only).
- Phases with zero duration are skipped, including at start. A program always ends with SPIN, then DONE.
- Prescaler counts 0..CLK_HZ-1 while `busy & ~pause`. It emits a one-cycle `tick` when it wraps.
- On `tick`:
  - If the countdown equals 01, advance to the next nonzero phase and load its duration. If none remain, go to DONE.
  - Otherwise decrement as BCD: `n0`=0 borrows to `n1`-1 and `n0`=9.
- Countdown never shows 00 while busy. All durations are 1..99 seconds.
- Display:
  - `n3` = phase code when busy, else blank.
  - `n2` = blank.
  - `{n1,n0}` = remaining seconds.
  - IDLE shows 0,0. DONE shows 0,0 with `n3` = 5.
- `st_light`:
  - Bit (phase-1) high for phases 1–4.
  - DONE = 8'hFF.
  - IDLE = 8'h00.
- DONE holds until an accepted start (new program) or `on` low (to IDLE).
- Priorities: `rst` > `on` low > `tick` > `start`. `start` while busy is ignored. `pause` high in a wrap cycle suppresses the tick; the prescaler holds its value.

## Timing
- Reset values:
  - state IDLE, `busy`=0, `done`=0, `bill_on`=0.
  - `phase`=0, `n3`=`n2`=11, `n1`=`n0`=0, `st_light`=8'h00.
  - prescaler = 0.
- Start accepted at edge k: state, countdown and `busy` update at edge k. The first tick occurs CLK_HZ cycles later.
- A phase of D seconds occupies exactly D·CLK_HZ unpaused cycles.
- Pause cycles extend the phase one-for-one.
- `done` is high only in the first DONE cycle.
- `on` low: IDLE at the next edge, with outputs at reset values.
- `rst` mid-program: immediate return to reset values. No resume.

## Structure
- Package `wash_pkg`:
  - state enum and phase codes.
  - `BLANK` = 4'd11.
  - 4×4 BCD duration table, indexed by mode and phase.
- Sub-module `sec_tick` (prescaler):
  - Parameter `CLK_HZ`.
  - Ports: `clk`, `rst`, `en`, `clr`, `tick`.
- Top: FSM, BCD countdown, and output decode, all registered.

## Test plan
Bench uses `CLK_HZ`=4.
- Reset, then idle 20 cycles → `n3`=`n2`=11, `n1`=`n0`=0, `st_light`=0, `busy`=0.
- mode0 start → FILL shows 1,_,1,0. After 40 cycles WASH shows 3,0. Total 300 cycles to DONE. `done` pulses once; `st_light`=FF.
- mode3 start → direct to SPIN, shows 1,5. DONE after 60 cycles.
- mode1, pause for 10 cycles during WASH → DONE arrives 10 cycles late. `bill_on` is low during the pause.
- Countdown 10 → 09 across a tick (BCD borrow). `start` pulses while busy → no effect.
- `on` low mid-RINSE → IDLE next edge. `rst` mid-SPIN → reset values immediately. A new start behaves as from reset.

Source files
------------

// File: rtl/wash_pkg.sv
// Shared types and constants for the washing-machine program sequencer.
package wash_pkg;

    // Sequencer states; the encoding doubles as the phase code shown on the display.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_WASH  = 3'd2,
        S_RINSE = 3'd3,
        S_SPIN  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Digit code that the display scanner renders as an unlit digit.
    localparam logic [3:0] BLANK = 4'd11;

    // Phase durations in BCD seconds, indexed [mode][phase], phase 0..3 = FILL..SPIN.
    localparam logic [0:3][0:3][7:0] DUR_TABLE = {
        8'h10, 8'h30, 8'h20, 8'h15,
        8'h05, 8'h15, 8'h10, 8'h10,
        8'h10, 8'h45, 8'h20, 8'h15,
        8'h00, 8'h00, 8'h00, 8'h15
    };

    // BCD duration of a state under a program; zero for IDLE and DONE.
    function automatic logic [7:0] phase_dur(input logic [1:0] mode, input state_t s);
        logic [7:0] d;
        case (s)
            S_FILL:  d = DUR_TABLE[mode][0];
            S_WASH:  d = DUR_TABLE[mode][1];
            S_RINSE: d = DUR_TABLE[mode][2];
            S_SPIN:  d = DUR_TABLE[mode][3];
            default: d = 8'h00;
        endcase
        return d;
    endfunction

    // First phase with a nonzero duration at table index >= first; DONE if none remain.
    // Later checks override earlier ones, so the lowest qualifying index wins.
    function automatic state_t next_phase(input logic [1:0] mode, input logic [2:0] first);
        state_t r;
        r = S_DONE;
        if (first <= 3'd3 && DUR_TABLE[mode][3] != 8'h00) r = S_SPIN;
        if (first <= 3'd2 && DUR_TABLE[mode][2] != 8'h00) r = S_RINSE;
        if (first <= 3'd1 && DUR_TABLE[mode][1] != 8'h00) r = S_WASH;
        if (first == 3'd0 && DUR_TABLE[mode][0] != 8'h00) r = S_FILL;
        return r;
    endfunction

endpackage

// File: rtl/wash_sequencer_sec_tick.sv
// One-second prescaler: counts enabled cycles and pulses tick on the wrap cycle.
module sec_tick #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_HZ - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear wins over counting; a disabled prescaler holds its value.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick = en & (count_q == LAST);

endmodule

// File: rtl/wash_sequencer.sv
// Wash program sequencer: FILL/WASH/RINSE/SPIN phase FSM with BCD seconds countdown
// and registered display/status decode.
module wash_sequencer
    import wash_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       on,
    input  logic       start,
    input  logic       pause,
    input  logic [1:0] mode,
    output logic       busy,
    output logic       done,
    output logic       bill_on,
    output logic [2:0] phase,
    output logic [3:0] n3,
    output logic [3:0] n2,
    output logic [3:0] n1,
    output logic [3:0] n0,
    output logic [7:0] st_light
);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] mode_q, mode_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [3:0] n3_q, n3_d;
    logic [7:0] light_q, light_d;

    logic       tick;
    logic       start_acc;
    state_t     nxt;

    // Start is only honoured from a resting state with power on.
    assign start_acc = on & start & ((state_q == S_IDLE) | (state_q == S_DONE));

    // Prescaler runs only while a phase is active and not paused; a new program restarts it.
    sec_tick #(
        .CLK_HZ(CLK_HZ)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (busy_q & ~pause),
        .clr  (start_acc | ~on),
        .tick (tick)
    );

    // Next state and countdown: power-off beats tick, tick beats start.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        nxt     = S_IDLE;
        if (!on) begin
            state_d = S_IDLE;
            cnt_d   = 8'h00;
        end else if (busy_q && tick) begin
            if (cnt_q == 8'h01) begin
                // State code equals the table index of the following phase.
                nxt     = next_phase(mode_q, state_q);
                state_d = nxt;
                cnt_d   = phase_dur(mode_q, nxt);
            end else if (cnt_q[3:0] == 4'd0) begin
                cnt_d = {cnt_q[7:4] - 4'd1, 4'd9};
            end else begin
                cnt_d = {cnt_q[7:4], cnt_q[3:0] - 4'd1};
            end
        end else if (start_acc) begin
            nxt     = next_phase(mode, 3'd0);
            mode_d  = mode;
            state_d = nxt;
            cnt_d   = phase_dur(mode, nxt);
        end
    end

    // Output decode from the next state so that outputs are registered alongside it.
    always_comb begin
        busy_d = (state_d == S_FILL) | (state_d == S_WASH) |
                 (state_d == S_RINSE) | (state_d == S_SPIN);
        done_d = (state_d == S_DONE) & (state_q != S_DONE);
        n3_d   = (busy_d || state_d == S_DONE) ? {1'b0, state_d} : BLANK;
    end

    // One light per active phase; every light on in DONE.
    for (genvar gi = 0; gi < 8; gi++) begin : g_light
        assign light_d[gi] = (state_d == S_DONE) |
                             (busy_d & ({1'b0, state_d} == 4'(gi + 1)));
    end

    // State, countdown and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'h00;
            mode_q  <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            n3_q    <= BLANK;
            light_q <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            n3_q    <= n3_d;
            light_q <= light_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign bill_on  = busy_q & ~pause;
    assign phase    = state_q;
    assign n3       = n3_q;
    assign n2       = BLANK;
    assign n1       = cnt_q[7:4];
    assign n0       = cnt_q[3:0];
    assign st_light = light_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// Bench for wash_sequencer: directed program runs plus randomized stimulus,
// every cycle compared against a seconds-level reference model.
module tb_wash_sequencer;

    localparam int HZ = 4;

    logic       clk = 1'b0;
    logic       rst, on, start, pause;
    logic [1:0] mode;
    logic       busy, done, bill_on;
    logic [2:0] phase;
    logic [3:0] n3, n2, n1, n0;
    logic [7:0] st_light;

    wash_sequencer #(.CLK_HZ(HZ)) dut (
        .clk(clk), .rst(rst), .on(on), .start(start), .pause(pause), .mode(mode),
        .busy(busy), .done(done), .bill_on(bill_on), .phase(phase),
        .n3(n3), .n2(n2), .n1(n1), .n0(n0), .st_light(st_light)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Program durations in seconds, [mode][FILL,WASH,RINSE,SPIN].
    int dur_tab [4][4] = '{'{10, 30, 20, 15}, '{5, 15, 10, 10}, '{10, 45, 20, 15}, '{0, 0, 0, 15}};

    // Reference model: current phase code, whole seconds left, cycles into current second,
    // and the queue of phases still to run.
    int   m_phase, m_secs, m_sub;
    logic m_done;
    int   q_code[$];
    int   q_secs[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic void m_reset();
        m_phase = 0; m_secs = 0; m_sub = 0; m_done = 1'b0;
        q_code.delete(); q_secs.delete();
    endfunction

    function automatic void m_advance();
        if (q_code.size() > 0) begin
            m_phase = q_code.pop_front();
            m_secs  = q_secs.pop_front();
        end else begin
            m_phase = 5; m_secs = 0; m_done = 1'b1;
        end
    endfunction

    // One clock edge of the model using the inputs present at that edge.
    function automatic void m_edge();
        m_done = 1'b0;
        if (rst) begin
            m_reset();
        end else if (!on) begin
            m_reset();
        end else if (m_phase >= 1 && m_phase <= 4) begin
            if (!pause) begin
                if (m_sub == HZ - 1) begin
                    m_sub = 0;
                    if (m_secs == 1) m_advance();
                    else m_secs--;
                end else begin
                    m_sub++;
                end
            end
        end else if (start) begin
            q_code.delete(); q_secs.delete();
            for (int p = 0; p < 4; p++)
                if (dur_tab[mode][p] != 0) begin
                    q_code.push_back(p + 1);
                    q_secs.push_back(dur_tab[mode][p]);
                end
            m_sub = 0;
            m_advance();
        end
    endfunction

    task automatic check_outputs();
        logic m_busy;
        logic [7:0] m_light;
        logic [3:0] m_n3;
        m_busy  = (m_phase >= 1 && m_phase <= 4);
        m_light = (m_phase == 5) ? 8'hFF : (m_busy ? (8'd1 << (m_phase - 1)) : 8'h00);
        m_n3    = (m_busy || m_phase == 5) ? 4'(m_phase) : 4'd11;
        chk("phase",    8'(phase),    8'(m_phase));
        chk("busy",     8'(busy),     8'(m_busy));
        chk("done",     8'(done),     8'(m_done));
        chk("bill_on",  8'(bill_on),  8'(m_busy & ~pause));
        chk("n3",       8'(n3),       8'(m_n3));
        chk("n2",       8'(n2),       8'd11);
        chk("n1",       8'(n1),       8'(m_secs / 10));
        chk("n0",       8'(n0),       8'(m_secs % 10));
        chk("st_light", st_light,     m_light);
    endtask

    // Advance one clock: update the model at the edge, compare on the falling edge.
    task automatic step();
        @(posedge clk);
        m_edge();
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic start_prog(input logic [1:0] md);
        mode  = md;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_to_done(input int t0, input int limit, output int len);
        while (!done && (cyc - t0) < limit) step();
        len = cyc - t0;
    endtask

    task automatic run_to_phase(input logic [2:0] target, input int limit);
        int n;
        n = 0;
        while (phase !== target && n < limit) begin
            step();
            n++;
        end
        chk("reach_phase", 8'(phase), 8'(target));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_phase"}, 8'(phase),    8'd0);
        chk({tag, "_busy"},  8'(busy),     8'd0);
        chk({tag, "_done"},  8'(done),     8'd0);
        chk({tag, "_bill"},  8'(bill_on),  8'd0);
        chk({tag, "_n3"},    8'(n3),       8'd11);
        chk({tag, "_n2"},    8'(n2),       8'd11);
        chk({tag, "_n1"},    8'(n1),       8'd0);
        chk({tag, "_n0"},    8'(n0),       8'd0);
        chk({tag, "_light"}, st_light,     8'h00);
    endtask

    initial begin
        int t0, len;
        rst = 1'b1; on = 1'b0; start = 1'b0; pause = 1'b0; mode = 2'd0;
        m_reset();
        #1;
        check_reset_values("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        on  = 1'b1;
        repeat (20) step();
        check_reset_values("idle");
        $display("step idle: 20 cycles after reset");

        // mode0 full program
        start_prog(2'd0);
        t0 = cyc;
        chk("m0_fill_n3", 8'(n3), 8'd1);
        chk("m0_fill_n1", 8'(n1), 8'd1);
        chk("m0_fill_n0", 8'(n0), 8'd0);
        repeat (40) step();
        chk("m0_wash_phase", 8'(phase), 8'd2);
        chk("m0_wash_n1", 8'(n1), 8'd3);
        chk("m0_wash_n0", 8'(n0), 8'd0);
        run_to_done(t0 - 40 + 40, 400, len);
        chk("m0_len", 8'(len), 8'(300));
        chk("m0_light", st_light, 8'hFF);
        step();
        chk("m0_done_once", 8'(done), 8'd0);
        $display("step mode0: done after %0d cycles", len);

        // mode3 spin only
        start_prog(2'd3);
        t0 = cyc;
        chk("m3_phase", 8'(phase), 8'd4);
        chk("m3_n1", 8'(n1), 8'd1);
        chk("m3_n0", 8'(n0), 8'd5);
        run_to_done(t0, 200, len);
        chk("m3_len", 8'(len), 8'd60);
        $display("step mode3: done after %0d cycles", len);

        // mode1 with a 10-cycle pause in WASH
        start_prog(2'd1);
        t0 = cyc;
        repeat (30) step();
        chk("m1_in_wash", 8'(phase), 8'd2);
        pause = 1'b1;
        repeat (10) begin
            step();
            chk("m1_bill_paused", 8'(bill_on), 8'd0);
        end
        pause = 1'b0;
        run_to_done(t0, 400, len);
        chk("m1_len", 8'(len), 8'd170);
        $display("step mode1 paused: done after %0d cycles", len);

        // BCD borrow 10 -> 09, then ignored starts while busy
        start_prog(2'd0);
        repeat (3) step();
        chk("borrow_pre_n1", 8'(n1), 8'd1);
        step();
        chk("borrow_n1", 8'(n1), 8'd0);
        chk("borrow_n0", 8'(n0), 8'd9);
        mode  = 2'd3;
        start = 1'b1;
        repeat (3) step();
        start = 1'b0;
        chk("busy_start_phase", 8'(phase), 8'd1);
        $display("step borrow and busy start: n1=%0d n0=%0d", n1, n0);

        // power off mid-RINSE
        run_to_phase(3'd3, 400);
        repeat (5) step();
        on = 1'b0;
        step();
        check_reset_values("off");
        on = 1'b1;
        step();
        $display("step power off in RINSE");

        // async reset mid-SPIN, then a fresh program
        start_prog(2'd2);
        run_to_phase(3'd4, 500);
        repeat (7) step();
        rst = 1'b1;
        #1;
        check_reset_values("arst");
        step();
        rst = 1'b0;
        step();
        start_prog(2'd3);
        t0 = cyc;
        run_to_done(t0, 200, len);
        chk("post_rst_len", 8'(len), 8'd60);
        $display("step reset in SPIN then mode3: done after %0d cycles", len);

        // randomized programs with pauses, spurious starts and rare power drops
        for (int r = 0; r < 10; r++) begin
            int budget;
            start_prog(2'($urandom_range(0, 3)));
            budget = 0;
            while (phase != 3'd5 && phase != 3'd0 && budget < 1500) begin
                pause = ($urandom_range(0, 5) == 0);
                start = ($urandom_range(0, 20) == 0);
                mode  = 2'($urandom_range(0, 3));
                on    = ($urandom_range(0, 700) != 0);
                step();
                budget++;
            end
            pause = 1'b0; start = 1'b0; on = 1'b1;
            step();
            $display("random program %0d: mode %0d ended in phase %0d after %0d cycles",
                     r, mode, phase, budget);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case a loop above misbehaves.
    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
